// File: rtl/res_port_arb.sv
// res_port_arb: two-requester arbiter for a single res memory port.
// Ports: clk/reset (async active-low); req_x, lock_x, rd_x, wr_x, addr_x, wdata_x per requester;
// gnt_x, rvalid_x, rdata back to requesters; res_rd/res_wr/res_addr/res_do/res_di to memory; busy.
// Define RES_ARB_RR_EN for round-robin tie-breaking; otherwise A wins every tie.
module res_port_arb #(
  parameter int MAX_HOLD = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        lock_a,
  input  logic        lock_b,
  input  logic        rd_a,
  input  logic        wr_a,
  input  logic        rd_b,
  input  logic        wr_b,
  input  logic [13:0] addr_a,
  input  logic [13:0] addr_b,
  input  logic [7:0]  wdata_a,
  input  logic [7:0]  wdata_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        rvalid_a,
  output logic        rvalid_b,
  output logic [7:0]  rdata,
  output logic        res_rd,
  output logic        res_wr,
  output logic [13:0] res_addr,
  output logic [7:0]  res_do,
  input  logic [7:0]  res_di,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  state_e state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic rdy_q, rvalid_a_q, rvalid_b_q, tie_b, own_a, own_b, rd, wr;
`ifdef RES_ARB_RR_EN
  // rr_q high means B won the last grant race least recently, so B takes the next tie
  logic rr_q, rr_d;
  assign rr_d = state_d == OWN_A ? 1'b1 : state_d == OWN_B ? 1'b0 : rr_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rr_q <= 1'b0;
    else rr_q <= rr_d;
  assign tie_b = rr_q;
`else
  assign tie_b = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rdy_q      <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rdy_q      <= 1'b1;
      rvalid_a_q <= res_rd & own_a;
      rvalid_b_q <= res_rd & own_b;
    end
  // rdy_q keeps the FSM in IDLE for the first edge after reset release
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (rdy_q) state_d = (req_a && req_b) ? (tie_b ? OWN_B : OWN_A) :
                                  req_a ? OWN_A : req_b ? OWN_B : IDLE;
      OWN_A: state_d = req_a ? ((hold_q == HOLD_MAX && req_b && !lock_a) ? OWN_B : OWN_A) :
                       req_b ? OWN_B : IDLE;
      OWN_B: state_d = req_b ? ((hold_q == HOLD_MAX && req_a && !lock_b) ? OWN_A : OWN_B) :
                       req_a ? OWN_A : IDLE;
      default: state_d = IDLE;
    endcase
    hold_d = (state_d != state_q) ? 8'd0 :
             (state_q != IDLE && hold_q != HOLD_MAX) ? hold_q + 8'd1 : hold_q;
  end
  assign own_a    = state_q == OWN_A;
  assign own_b    = state_q == OWN_B;
  assign rd       = (own_a & rd_a) | (own_b & rd_b);
  assign wr       = (own_a & wr_a) | (own_b & wr_b);
  assign res_rd   = rd & ~wr;
  assign res_wr   = wr;
  assign res_addr = own_a ? addr_a : own_b ? addr_b : 14'd0;
  assign res_do   = own_a ? wdata_a : own_b ? wdata_b : 8'd0;
  assign gnt_a    = own_a;
  assign gnt_b    = own_b;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign rdata    = res_di;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_res_port_arb.sv
// tb_res_port_arb: vector-table bench for res_port_arb with MAX_HOLD=4
module tb_res_port_arb;
  logic clk = 1'b0, reset = 1'b0;
  logic req_a = 0, req_b = 0, lock_a = 0, lock_b = 0, rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
  logic [13:0] addr_a = 14'h0081, addr_b = 14'h1234, res_addr;
  logic [7:0] wdata_a = 8'h5A, wdata_b = 8'hC3, res_di = 8'h00, res_do, rdata;
  logic gnt_a, gnt_b, rvalid_a, rvalid_b, res_rd, res_wr, busy;
  int checks = 0, passed = 0;
  typedef struct {
    string       nm;
    logic [8:0]  ctl;
    logic [7:0]  di;
    logic [6:0]  eo;
  } vec_t;
  vec_t vecs[$];
  vec_t exp_q[$];
  res_port_arb #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .lock_a(lock_a), .lock_b(lock_b),
    .rd_a(rd_a), .wr_a(wr_a), .rd_b(rd_b), .wr_b(wr_b), .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b), .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a),
    .rvalid_b(rvalid_b), .rdata(rdata), .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr),
    .res_do(res_do), .res_di(res_di), .busy(busy)
  );
  always #5 clk = ~clk;
  // ctl = {reset_n, req_a, req_b, lock_a, lock_b, rd_a, wr_a, rd_b, wr_b}
  // eo  = {gnt_a, gnt_b, rvalid_a, rvalid_b, res_rd, res_wr, busy}
  task automatic add(input string nm, input logic [8:0] ctl, input logic [7:0] di, input logic [6:0] eo);
    vec_t v;
    v.nm = nm; v.ctl = ctl; v.di = di; v.eo = eo;
    vecs.push_back(v);
  endtask
  task automatic run(input vec_t v);
    vec_t e;
    logic [13:0] ea;
    logic [7:0] ed;
    logic [36:0] got, want;
    @(negedge clk);
    {reset, req_a, req_b, lock_a, lock_b, rd_a, wr_a, rd_b, wr_b} = v.ctl;
    res_di = v.di;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    ea = e.eo[6] ? 14'h0081 : e.eo[5] ? 14'h1234 : 14'h0000;
    ed = e.eo[6] ? 8'h5A : e.eo[5] ? 8'hC3 : 8'h00;
    got  = {gnt_a, gnt_b, rvalid_a, rvalid_b, res_rd, res_wr, busy, res_addr, res_do, rdata};
    want = {e.eo, ea, ed, e.di};
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got ctl=%b addr=%h do=%h rdata=%h, expected ctl=%b addr=%h do=%h rdata=%h",
                  e.nm, got[36:30], got[29:16], got[15:8], got[7:0], e.eo, ea, ed, e.di);
  endtask
  initial begin
    add("reset",        9'b0_10_00_00_00, 8'h11, 7'b00_00_00_0);
    add("release",      9'b1_10_00_00_00, 8'h00, 7'b00_00_00_0);
    add("release2",     9'b1_10_00_00_00, 8'h00, 7'b00_00_00_0);
    add("a_read",       9'b1_10_00_10_00, 8'h00, 7'b10_00_10_1);
    add("a_rvalid",     9'b1_10_00_00_00, 8'hA7, 7'b10_10_00_1);
    add("b2b_rd1",      9'b1_10_00_10_00, 8'h00, 7'b10_00_10_1);
    add("b2b_rd2",      9'b1_10_00_10_00, 8'h3C, 7'b10_10_10_1);
    add("b2b_done",     9'b1_10_00_00_00, 8'h99, 7'b10_10_00_1);
    add("b_ignored",    9'b1_10_00_00_11, 8'h00, 7'b10_00_00_1);
    add("rw_conflict",  9'b1_10_00_11_00, 8'h00, 7'b10_00_01_1);
    add("rw_no_rvalid", 9'b1_10_00_00_00, 8'h00, 7'b10_00_00_1);
    add("a_drop",       9'b1_00_00_00_00, 8'h00, 7'b10_00_00_1);
    add("idle_ignored", 9'b1_00_00_11_00, 8'h00, 7'b00_00_00_0);
    add("a_again",      9'b1_10_00_00_00, 8'h00, 7'b00_00_00_0);
    // counter reaches MAX_HOLD after 4 owned cycles; the handover edge follows that cycle
    for (int i = 0; i < 4; i++) add($sformatf("hold%0d", i), 9'b1_11_00_00_00, 8'h00, 7'b10_00_00_1);
    add("hold_last_rd", 9'b1_11_00_10_00, 8'h00, 7'b10_00_10_1);
    add("forced_b",     9'b1_11_00_00_00, 8'h6E, 7'b01_10_00_1);
    add("b_drop",       9'b1_10_00_00_00, 8'h00, 7'b01_00_00_1);
    for (int i = 0; i < 20; i++) add($sformatf("lock%0d", i), 9'b1_11_10_00_00, 8'h00, 7'b10_00_00_1);
    add("unlock",       9'b1_11_00_00_00, 8'h00, 7'b10_00_00_1);
    add("b_read",       9'b1_11_00_00_10, 8'h00, 7'b01_00_10_1);
    add("b_read2",      9'b1_01_00_00_10, 8'h42, 7'b01_01_10_1);
    add("reset_b",      9'b0_01_00_00_00, 8'h24, 7'b00_00_00_0);
    for (int i = 0; i < vecs.size(); i++) run(vecs[i]);
    vecs.delete();
    add("tie_rel",      9'b1_11_00_00_00, 8'h00, 7'b00_00_00_0);
    add("tie_wait",     9'b1_11_00_00_00, 8'h00, 7'b00_00_00_0);
    add("tie1",         9'b1_11_00_00_00, 8'h00, 7'b10_00_00_1);
    add("tie_drop",     9'b1_00_00_00_00, 8'h00, 7'b10_00_00_1);
    add("tie_idle",     9'b1_11_00_00_00, 8'h00, 7'b00_00_00_0);
`ifdef RES_ARB_RR_EN
    add("tie2",         9'b1_11_00_00_00, 8'h00, 7'b01_00_00_1);
    add("tie2_drop",    9'b1_00_00_00_00, 8'h00, 7'b01_00_00_1);
`else
    add("tie2",         9'b1_11_00_00_00, 8'h00, 7'b10_00_00_1);
    add("tie2_drop",    9'b1_00_00_00_00, 8'h00, 7'b10_00_00_1);
`endif
    add("mr_idle",      9'b1_10_00_00_00, 8'h00, 7'b00_00_00_0);
    add("mr_read",      9'b1_10_00_10_00, 8'h00, 7'b10_00_10_1);
    add("mr_reset",     9'b0_10_00_10_00, 8'h5F, 7'b00_00_00_0);
    add("mr_after",     9'b1_00_00_00_00, 8'h00, 7'b00_00_00_0);
    for (int i = 0; i < vecs.size(); i++) run(vecs[i]);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
